// File: rtl/serial_paralelo.sv
// Receive side of the 9-bit parallel/serial link: aligns to COMMA bytes in an MSB-first bit
// stream and, once locked, emits each received byte as {valid, data} with a one-cycle strobe.
module serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset_L,
  input  logic       serial_in,
  output logic [8:0] paralelo_out,
  output logic       paralelo_strobe,
  output logic       active
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [3:0] SyncCnt = 4'(SYNC_COUNT);

  logic [7:0] shift_q;
  logic [7:0] cand;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [1:0] state_q, state_d;
  logic [8:0] out_q, out_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;
  logic       is_comma;
  logic       boundary;

  // Byte as it will look once the current bit lands, so decisions happen on the LSB edge.
  assign cand     = {shift_q[6:0], serial_in};
  assign is_comma = (cand == COMMA);
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    state_d     = state_q;
    out_d       = out_q;
    strobe_d    = 1'b0;
    active_d    = active_q;

    case (state_q)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          if (SyncCnt == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_d == SyncCnt) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // Drop back to bit-by-bit hunting; this byte is not re-examined.
            comma_cnt_d = 4'd0;
            state_d     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          out_d    = is_comma ? 9'h000 : {1'b1, cand};
        end
      end

      default: begin
        state_d  = SEARCH;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      state_q     <= SEARCH;
      out_q       <= 9'h000;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      shift_q     <= cand;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      state_q     <= state_d;
      out_q       <= out_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign paralelo_out    = out_q;
  assign paralelo_strobe = strobe_q;
  assign active          = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboard bench for serial_paralelo: default instance plus a SYNC_COUNT=1 instance.
module tb_serial_paralelo;

  logic       clk8f = 1'b0;
  logic       rst0;
  logic       rst1;
  logic       serial_in;
  logic [8:0] out0, out1;
  logic       stb0, stb1;
  logic       act0, act1;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         prev0   = 0;
  bit         have_prev0 = 1'b0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  always #5 clk8f = ~clk8f;

  always @(posedge clk8f) cyc++;

  serial_paralelo dut (
    .clk8f           (clk8f),
    .reset_L         (rst0),
    .serial_in       (serial_in),
    .paralelo_out    (out0),
    .paralelo_strobe (stb0),
    .active          (act0)
  );

  serial_paralelo #(
    .COMMA      (8'hBC),
    .SYNC_COUNT (1)
  ) dut1 (
    .clk8f           (clk8f),
    .reset_L         (rst1),
    .serial_in       (serial_in),
    .paralelo_out    (out1),
    .paralelo_strobe (stb1),
    .active          (act1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] word_of(input logic [7:0] b);
    return (b == 8'hBC) ? 9'h000 : {1'b1, b};
  endfunction

  always @(negedge clk8f) begin
    if (stb0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("stray_strobe0", 32'(stb0), 32'h0);
      end else begin
        check("word0", 32'(out0), 32'(q0.pop_front()));
        if (have_prev0) check("spacing0", 32'(cyc - prev0), 32'd8);
        prev0      = cyc;
        have_prev0 = 1'b1;
      end
    end
  end

  always @(negedge clk8f) begin
    if (stb1 === 1'b1) begin
      if (q1.size() == 0) check("stray_strobe1", 32'(stb1), 32'h0);
      else check("word1", 32'(out1), 32'(q1.pop_front()));
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk8f);
    serial_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    q0.push_back(word_of(b));
    send_byte(b);
  endtask

  // Sample just after the edge that captured the last driven bit.
  task automatic after_edge();
    @(posedge clk8f);
    #1;
  endtask

  task automatic reset0();
    @(negedge clk8f);
    rst0      = 1'b0;
    serial_in = 1'b0;
    #1;
    check("rst_out0", 32'(out0), 32'h000);
    check("rst_stb0", 32'(stb0), 32'h0);
    check("rst_act0", 32'(act0), 32'h0);
    repeat (2) @(negedge clk8f);
    rst0       = 1'b1;
    have_prev0 = 1'b0;
  endtask

  task automatic drain0(input string tag);
    @(negedge clk8f);
    serial_in = 1'b0;
    @(negedge clk8f);
    check({"leftover_", tag}, 32'(q0.size()), 32'd0);
  endtask

  task automatic lock_sequence(input string tag);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    after_edge();
    check({"prelock_", tag}, 32'(act0), 32'h0);
    send_byte(8'hBC);
    after_edge();
    check({"lock_", tag}, 32'(act0), 32'h1);
  endtask

  initial begin
    serial_in = 1'b0;
    rst0      = 1'b0;
    rst1      = 1'b0;
    repeat (2) @(negedge clk8f);

    // Basic lock and data
    reset0();
    lock_sequence("basic");
    expect_byte(8'hFF);
    expect_byte(8'h55);
    expect_byte(8'h00);
    drain0("basic");

    // Misaligned start
    reset0();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock_sequence("misalign");
    expect_byte(8'h30);
    drain0("misalign");
    check("misalign_out", 32'(out0), 32'h130);
    check("misalign_act", 32'(act0), 32'h1);

    // Broken sync then relock
    reset0();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    after_edge();
    check("broken_act", 32'(act0), 32'h0);
    lock_sequence("relock");
    expect_byte(8'hF0);
    drain0("relock");
    check("relock_out", 32'(out0), 32'h1F0);

    // Idle bytes while active
    reset0();
    lock_sequence("idle");
    expect_byte(8'hFF);
    expect_byte(8'hBC);
    expect_byte(8'hBC);
    expect_byte(8'h55);
    drain0("idle");

    // Asynchronous reset in the middle of a data byte
    reset0();
    lock_sequence("midrst");
    expect_byte(8'h3C);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("midrst_pre_out", 32'(out0), 32'h13C);
    @(negedge clk8f);
    #2;
    rst0 = 1'b0;
    #1;
    check("midrst_act", 32'(act0), 32'h0);
    check("midrst_out", 32'(out0), 32'h000);
    check("midrst_stb", 32'(stb0), 32'h0);
    serial_in = 1'b0;
    @(negedge clk8f);
    rst0       = 1'b1;
    have_prev0 = 1'b0;
    lock_sequence("postrst");
    expect_byte(8'h00);
    drain0("postrst");
    check("postrst_out", 32'(out0), 32'h100);

    // SYNC_COUNT = 1 instance
    @(negedge clk8f);
    rst0 = 1'b0;
    #1;
    check("p1_rst_act", 32'(act1), 32'h0);
    @(negedge clk8f);
    rst1 = 1'b1;
    send_byte(8'h00);
    after_edge();
    check("p1_prelock", 32'(act1), 32'h0);
    send_byte(8'hBC);
    after_edge();
    check("p1_lock", 32'(act1), 32'h1);
    q1.push_back(9'h1AA);
    send_byte(8'hAA);
    @(negedge clk8f);
    serial_in = 1'b0;
    @(negedge clk8f);
    check("leftover_p1", 32'(q1.size()), 32'd0);
    check("p1_out", 32'(out1), 32'h1AA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive end of the 9-bit parallel/serial link. Deserializes the single-bit stream produced by the paralelo-to-serial transmitter.
- Word format is {valid, data[7:0]}. The transmitter sends valid words as their data byte. It sends invalid words and idle as the COMMA byte. Bytes go MSB first, one bit per clk8f cycle.
- The block finds byte alignment from COMMA bytes, declares lock after SYNC_COUNT consecutive aligned COMMAs, then presents each received byte as a 9-bit word with a one-cycle strobe.

Parameters:
- COMMA, 8'hBC, idle/invalid symbol used for alignment.
- SYNC_COUNT, 4, consecutive aligned COMMAs needed to enter ACTIVE (range 1..15).

Ports:
- clk8f  input  1  bit clock; one serial bit sampled per rising edge.
- reset_L  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data, MSB of each byte first.
- paralelo_out  output  9  {valid, data[7:0]} of the last completed byte.
- paralelo_strobe  output  1  one-cycle pulse when paralelo_out updates.
- active  output  1  high while locked (state ACTIVE).

Behaviour:
- Reset (reset_L=0, asynchronous):
  - shift=8'h00, bit_cnt=0, comma_cnt=0, state=SEARCH.
  - paralelo_out=9'h000, paralelo_strobe=0, active=0.
  - Reset deassertion is sampled synchronously. The first bit is captured at the first rising edge with reset_L=1.
- Shifting:
  - Every edge: shift <= {shift[6:0], serial_in}.
  - Candidate byte cand = {shift[6:0], serial_in}, combinational, always evaluated on the current edge.
- bit_cnt, 3 bits:
  - Counts bit position within the aligned byte. Wraps 7->0.
  - A byte boundary is an edge where bit_cnt==7.
- SEARCH:
  - Evaluates cand every edge, ignoring bit_cnt.
  - If cand==COMMA: bit_cnt<=0, comma_cnt<=1, go to ALIGN. If SYNC_COUNT==1, go directly to ACTIVE instead.
  - Otherwise stay in SEARCH. No outputs change.
- ALIGN:
  - bit_cnt increments each edge. Only byte boundaries are evaluated.
  - At a boundary, cand==COMMA: comma_cnt++. If the new count equals SYNC_COUNT, go to ACTIVE and set active<=1 on that edge.
  - At a boundary, cand!=COMMA: comma_cnt<=0, go to SEARCH. The mismatching byte is not re-scanned as a COMMA candidate.
  - paralelo_out and paralelo_strobe stay unchanged/0 in ALIGN.
- ACTIVE:
  - At each byte boundary, paralelo_strobe<=1 for exactly one cycle.
  - If cand==COMMA: paralelo_out<=9'h000, i.e. an invalid word.
  - Otherwise: paralelo_out<={1'b1, cand}.
  - Between boundaries: paralelo_strobe=0 and paralelo_out holds.
  - ACTIVE persists until reset. Loss of lock is not detected.
- Latency: paralelo_out and paralelo_strobe update on the same edge that samples bit 0 (LSB) of the byte.
- Valid data equal to COMMA is indistinguishable from idle and is reported invalid. The transmitter never sends it as valid.
- Reset asserted mid-byte or in any state returns immediately to the reset values. A partial byte is discarded.

Test Plan:
- Lock: after reset, send BC,BC,BC,BC,FF,55,00.
  - active rises on the LSB edge of the 4th BC.
  - Outputs are then 9'h1FF, 9'h155, 9'h100, with strobes exactly 8 cycles apart.
  - No strobe before lock.
- Misaligned start: send bits 1,0,1 then BC x4, 30.
  - Locks on the true BC boundary.
  - First output is 9'h130. active=1.
- Broken sync: send BC,BC,55 -> active stays 0 and the FSM returns to SEARCH. Then send BC x4, F0 -> locks, paralelo_out=9'h1F0.
- Idle while active: after lock, send FF,BC,BC,55.
  - Outputs are 9'h1FF, 9'h000, 9'h000, 9'h155.
  - Each byte gives exactly one strobe.
- Reset mid-operation: pull reset_L low at bit 3 of a data byte while ACTIVE.
  - Immediately active=0, paralelo_out=9'h000, paralelo_strobe=0.
  - Release reset, then send BC x4, 00 -> paralelo_out=9'h100.
- Parameter check: with SYNC_COUNT=1, a single BC asserts active; the next 0xAA yields 9'h1AA.
